// File: rtl/jtag_tap_master.sv
// Command-driven IEEE 1149.1 TAP sequencer: RESET / IDLE / SCAN_IR / SCAN_DR over valid/ready.
// Define TAP_MASTER_PAUSE_EN to route every scan through Pause_xR for PAUSE_CYCLES cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_START | held after rst; launches the silent power-up reset sequence
// ST_RESET | five TMS=1 then one TMS=0 (Test_Logic_Reset -> Run_Idle)
// ST_READY | parked in Run_Idle, cmd_ready high
// ST_IDLE  | TMS=0 for the requested number of cycles
// ST_PRE   | Select_DR [Select_IR] Capture Shift entry
// ST_SHIFT | one cycle per scan bit, TMS=1 on the last
// ST_PAUSE | Pause_xR dwell (pause build only)
// ST_POST  | [Exit2] Update then back to Run_Idle
// ST_ERR   | illegal scan length, one quiet cycle before the error response
module jtag_tap_master #(
    parameter int MAX_LEN      = 16,
    parameter int LEN_W        = 5,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic               TCK,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               TDO,
    output logic               TMS,
    output logic               TDI,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err
);

    localparam int PAUSE_W = $clog2(PAUSE_CYCLES + 1) + 1;
    localparam int CNT_W0  = (LEN_W > PAUSE_W) ? LEN_W : PAUSE_W;
    localparam int CNT_W   = (CNT_W0 > 3) ? CNT_W0 : 3;

    typedef enum logic [3:0] {
        ST_START, ST_RESET, ST_READY, ST_IDLE, ST_PRE,
        ST_SHIFT, ST_PAUSE, ST_POST, ST_ERR
    } ctl_t;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0, TAP_EXIT1_DR  = 4'h1, TAP_SHIFT_DR  = 4'h2, TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4, TAP_UPDATE_DR = 4'h5, TAP_CAP_DR    = 4'h6, TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8, TAP_EXIT1_IR  = 4'h9, TAP_SHIFT_IR  = 4'hA, TAP_PAUSE_IR  = 4'hB,
        TAP_RUN_IDLE  = 4'hC, TAP_UPDATE_IR = 4'hD, TAP_CAP_IR    = 4'hE, TAP_TLR       = 4'hF
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        tap_t n;
        n = s;
        case (s)
            TAP_TLR:       n = tms ? TAP_TLR      : TAP_RUN_IDLE;
            TAP_RUN_IDLE:  n = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
            TAP_SEL_DR:    n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:    n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  n = tms ? TAP_UPDATE_DR: TAP_PAUSE_DR;
            TAP_PAUSE_DR:  n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  n = tms ? TAP_UPDATE_DR: TAP_SHIFT_DR;
            TAP_UPDATE_DR: n = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
            TAP_SEL_IR:    n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:    n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  n = tms ? TAP_UPDATE_IR: TAP_PAUSE_IR;
            TAP_PAUSE_IR:  n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  n = tms ? TAP_UPDATE_IR: TAP_SHIFT_IR;
            TAP_UPDATE_IR: n = tms ? TAP_SEL_DR   : TAP_RUN_IDLE;
            default:       n = TAP_TLR;
        endcase
        return n;
    endfunction

    ctl_t               state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    tap_t               tap_state;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_sr;
    logic [MAX_LEN-1:0] cap;
    logic [MAX_LEN-1:0] bit_sel;
    logic               silent;
    logic               len_ok;
    logic               tms_nxt, tdi_nxt, ready_nxt, done_nxt;

    assign len_ok = (cmd_len != '0) && (int'(cmd_len) <= MAX_LEN);

    always_ff @(posedge TCK) begin : state_reg
        if (rst) begin
            state <= ST_START;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt is a down-counter; every phase ends on its terminal count of zero
    always_comb begin : next_state_comb
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_START: begin
                state_nxt = ST_RESET;
                cnt_nxt   = CNT_W'(5);
            end
            ST_RESET, ST_IDLE, ST_POST: begin
                if (cnt == '0) state_nxt = ST_READY;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_READY: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        2'b00: begin
                            state_nxt = ST_RESET;
                            cnt_nxt   = CNT_W'(5);
                        end
                        2'b01: begin
                            state_nxt = ST_IDLE;
                            cnt_nxt   = (cmd_len == '0) ? '0 : CNT_W'(cmd_len - LEN_W'(1));
                        end
                        default: begin
                            if (len_ok) begin
                                state_nxt = ST_PRE;
                                cnt_nxt   = cmd_op[0] ? CNT_W'(2) : CNT_W'(3);
                            end else begin
                                state_nxt = ST_ERR;
                            end
                        end
                    endcase
                end
            end
            ST_PRE: begin
                if (cnt == '0) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = CNT_W'(len_q - LEN_W'(1));
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
`ifdef TAP_MASTER_PAUSE_EN
                    state_nxt = ST_PAUSE;
                    cnt_nxt   = CNT_W'(PAUSE_CYCLES - 1);
`else
                    state_nxt = ST_POST;
                    cnt_nxt   = CNT_W'(1);
`endif
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (cnt == '0) begin
                    state_nxt = ST_POST;
                    cnt_nxt   = CNT_W'(2);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_ERR:  state_nxt = ST_READY;
            default: state_nxt = ST_START;
        endcase
    end

    // TMS/TDI are decoded from the next phase so the pins come straight off flops
    always_comb begin : output_comb
        tms_nxt = 1'b0;
        tdi_nxt = 1'b1;
        case (state_nxt)
            ST_START:         tms_nxt = 1'b1;
            ST_RESET, ST_POST: tms_nxt = (cnt_nxt != '0);
            ST_PRE:           tms_nxt = cnt_nxt[1];
            ST_SHIFT: begin
                tms_nxt = (cnt_nxt == '0);
                tdi_nxt = (state == ST_SHIFT) ? data_sr[1] : data_sr[0];
            end
            default:          tms_nxt = 1'b0;
        endcase
        ready_nxt = (state_nxt == ST_READY);
        done_nxt  = ready_nxt && (state != ST_READY) && !silent;
    end

    always_ff @(posedge TCK) begin : datapath_reg
        if (rst) begin
            TMS       <= 1'b1;
            TDI       <= 1'b1;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            silent    <= 1'b1;
            tap_state <= TAP_TLR;
            len_q     <= '0;
            data_sr   <= '0;
            cap       <= '0;
            bit_sel   <= '0;
        end else begin
            TMS       <= tms_nxt;
            TDI       <= tdi_nxt;
            cmd_ready <= ready_nxt;
            rsp_valid <= done_nxt;
            tap_state <= tap_next(tap_state, TMS);
            if (done_nxt) begin
                rsp_data <= cap;
                rsp_err  <= (state == ST_ERR);
            end
            if (cmd_valid && cmd_ready) begin
                len_q   <= cmd_len;
                data_sr <= cmd_data;
                cap     <= '0;
                bit_sel <= MAX_LEN'(1);
                silent  <= 1'b0;
            end else begin
                if (state == ST_SHIFT) data_sr <= data_sr >> 1;
                // the target presents bit i while the tracked TAP sits in Shift
                if (tap_state == TAP_SHIFT_DR || tap_state == TAP_SHIFT_IR) begin
                    if (TDO) cap <= cap | bit_sel;
                    bit_sel <= bit_sel << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Bench for jtag_tap_master: behavioural TAP target (3-bit IR capturing 101, 1-bit BYPASS DR)
// plus rule-built TMS/TDI traces and scan responses; honours TAP_MASTER_PAUSE_EN.
module tb_jtag_tap_master;

    localparam int MAX_LEN      = 16;
    localparam int LEN_W        = 5;
    localparam int PAUSE_CYCLES = 4;
`ifdef TAP_MASTER_PAUSE_EN
    localparam int NPAUSE = PAUSE_CYCLES;
`else
    localparam int NPAUSE = 0;
`endif

    logic               TCK = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op = '0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               TDO;
    logic               cmd_ready, TMS, TDI, rsp_valid, rsp_err;
    logic [MAX_LEN-1:0] rsp_data;

    jtag_tap_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .PAUSE_CYCLES(PAUSE_CYCLES)) dut (
        .TCK(TCK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .TDO(TDO),
        .TMS(TMS), .TDI(TDI), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 TCK = ~TCK;

    // target TAP: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR 7 Ex2DR 8 UpdDR
    //             9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
    int nt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int       ms    = 0;
    logic [2:0] ir    = 3'b111;
    logic [2:0] ir_sr = 3'b000;
    logic       byp   = 1'b0;

    always @(posedge TCK) begin
        case (ms)
            0:  ir    <= 3'b111;
            3:  byp   <= 1'b0;
            4:  byp   <= TDI;
            10: ir_sr <= 3'b101;
            11: ir_sr <= {TDI, ir_sr[2:1]};
            15: ir    <= ir_sr;
            default: ;
        endcase
        ms <= TMS ? nt1[ms] : nt0[ms];
    end

    assign TDO = (ms == 11) ? ir_sr[0] : (ms == 4) ? byp : 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic tap_check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] e_tms, e_tdi, o_tms, o_tdi;
    int          e_n, o_n;
    logic [63:0] last_rsp = '0;
    logic        last_err = 1'b0;
    logic [2:0]  exp_ir   = 3'b111;

    task automatic push(input logic t, input logic d);
        e_tms[e_n] = t;
        e_tdi[e_n] = d;
        e_n++;
    endtask

    // caller sits at a negedge; rst is held for ncyc edges, then the silent boot sequence is traced
    task automatic do_reset(input int ncyc);
        logic got_rsp;
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (ncyc) begin
            @(negedge TCK);
            tap_check("rst_pins", {TMS, TDI, cmd_ready}, 3'b110);
            tap_check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
        end
        rst = 1'b0;
        e_n = 0; e_tms = '0; e_tdi = '0;
        repeat (5) push(1'b1, 1'b1);
        push(1'b0, 1'b1);
        o_n = 0; o_tms = '0; o_tdi = '0; got_rsp = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge TCK);
            if (rsp_valid) got_rsp = 1'b1;
            if (cmd_ready) break;
            o_tms[o_n] = TMS;
            o_tdi[o_n] = TDI;
            o_n++;
        end
        tap_check("boot_len", o_n, e_n);
        tap_check("boot_tms", o_tms, e_tms);
        tap_check("boot_tdi", o_tdi, e_tdi);
        tap_check("boot_no_rsp", got_rsp, 1'b0);
        tap_check("boot_ready", cmd_ready, 1'b1);
        tap_check("boot_tap_state", ms, 1);
        tap_check("boot_ir", ir, 3'b111);
        last_rsp = '0; last_err = 1'b0; exp_ir = 3'b111;
    endtask

    task automatic issue(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data);
        for (int w = 0; w < 100 && !cmd_ready; w++) @(negedge TCK);
        tap_check("ready_before_cmd", cmd_ready, 1'b1);
        tap_check("rsp_hold", {rsp_err, rsp_data}, {last_err, last_rsp[MAX_LEN-1:0]});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        @(posedge TCK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data);
        logic        legal, got, x_err;
        logic [63:0] v, mask, x_rsp;
        int          pauses, x_pause;
        issue(op, len, data);
        legal = (len >= 1) && (len <= MAX_LEN);
        e_n = 0; e_tms = '0; e_tdi = '0;
        x_rsp = '0; x_err = 1'b0; x_pause = 0;
        mask = (64'd1 << len) - 64'd1;
        case (op)
            2'b00: begin
                repeat (5) push(1'b1, 1'b1);
                push(1'b0, 1'b1);
                exp_ir = 3'b111;
            end
            2'b01: repeat ((len == 0) ? 1 : len) push(1'b0, 1'b1);
            default: begin
                if (!legal) begin
                    push(1'b0, 1'b1);
                    x_err = 1'b1;
                end else begin
                    push(1'b1, 1'b1);
                    if (op == 2'b10) push(1'b1, 1'b1);
                    push(1'b0, 1'b1);
                    push(1'b0, 1'b1);
                    for (int i = 0; i < len; i++) push(i == len - 1, data[i]);
                    repeat (NPAUSE) push(1'b0, 1'b1);
                    if (NPAUSE > 0) push(1'b1, 1'b1);
                    push(1'b1, 1'b1);
                    push(1'b0, 1'b1);
                    x_pause = NPAUSE;
                    if (op == 2'b10) begin
                        v      = ({48'd0, data} << 3) | 64'd5;
                        x_rsp  = v & mask;
                        exp_ir = 3'((v >> len) & 64'd7);
                    end else begin
                        x_rsp = ({48'd0, data} << 1) & mask;
                    end
                end
            end
        endcase
        o_n = 0; o_tms = '0; o_tdi = '0; got = 1'b0; pauses = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge TCK);
            if (rsp_valid) begin
                cmd_valid = 1'b0;
                got = 1'b1;
                break;
            end
            o_tms[o_n] = TMS;
            o_tdi[o_n] = TDI;
            o_n++;
            if (ms == 6 || ms == 13) pauses++;
            // busy: cmd_* must be ignored
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom);
            cmd_len   = LEN_W'($urandom);
            cmd_data  = MAX_LEN'($urandom);
        end
        tap_check("rsp_seen", got, 1'b1);
        tap_check("cmd_cycles", o_n, e_n);
        tap_check("tms_trace", o_tms, e_tms);
        tap_check("tdi_trace", o_tdi, e_tdi);
        tap_check("rsp_err", rsp_err, x_err);
        tap_check("rsp_data", rsp_data, x_rsp);
        tap_check("ready_with_rsp", cmd_ready, 1'b1);
        tap_check("tap_in_run_idle", ms, 1);
        tap_check("target_ir", ir, exp_ir);
        tap_check("pause_cycles", pauses, x_pause);
        last_rsp = x_rsp;
        last_err = x_err;
    endtask

    initial begin : stim
        logic got;
        do_reset(3);
        run_cmd(2'b10, 3, MAX_LEN'(3'b011));
        tap_check("ir_loaded_011", ir, 3'b011);
        run_cmd(2'b00, 0, '0);
        run_cmd(2'b11, 14, MAX_LEN'(14'h2AAA));
        tap_check("bypass_rsp_1554", rsp_data, MAX_LEN'(14'h1554));
        run_cmd(2'b11, 0, MAX_LEN'(16'hFFFF));
        run_cmd(2'b11, 17, MAX_LEN'(16'h1234));
        run_cmd(2'b10, 0, '0);
        run_cmd(2'b01, 0, '0);
        run_cmd(2'b01, 4, '0);
        run_cmd(2'b11, MAX_LEN, MAX_LEN'(16'hC3A5));
        run_cmd(2'b11, 1, MAX_LEN'(1));
        run_cmd(2'b10, 1, '0);
        run_cmd(2'b11, 2, MAX_LEN'(2'b01));

        // abort on the 5th shift edge of a 14-bit DR scan
        issue(2'b11, 14, MAX_LEN'(14'h2AAA));
        got = 1'b0;
        repeat (8) begin
            @(negedge TCK);
            if (rsp_valid) got = 1'b1;
        end
        tap_check("abort_no_rsp_before", got, 1'b0);
        do_reset(1);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] op;
            int len;
            op  = 2'($urandom_range(0, 3));
            len = $urandom_range(0, MAX_LEN + 3);
            repeat ($urandom_range(0, 2)) @(negedge TCK);
            run_cmd(op, len, MAX_LEN'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
